// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshake signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data requesters, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for alternating tie-breaks; otherwise data always wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {FETCH, DATA} owner_t;

  state_t state, state_next;
  owner_t owner, owner_next;

  logic grant_if;
  logic grant_dm;
  logic tie_to_dm;
  logic complete;

  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  if_rvalid_q;
  logic                  dm_rvalid_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] dm_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_to_dm = (owner == FETCH);
`else
  assign tie_to_dm = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= FETCH;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.if_req && bus.dm_req) begin
          grant_dm = tie_to_dm;
          grant_if = !tie_to_dm;
        end else begin
          grant_dm = bus.dm_req;
          grant_if = bus.if_req;
        end
        if (grant_if || grant_dm) begin
          state_next = BUSY;
          owner_next = grant_dm ? DATA : FETCH;
        end
      end
      BUSY: begin
        complete = bus.mem_ack;
        if (bus.mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grants are combinational, so keep them quiet while reset is held.
  assign bus.if_gnt = grant_if && !reset;
  assign bus.dm_gnt = grant_dm && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if (grant_if) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.if_addr;
        mem_wdata_q <= '0;
      end else if (grant_dm) begin
        mem_we_q    <= bus.dm_we;
        mem_addr_q  <= bus.dm_addr;
        mem_wdata_q <= bus.dm_wdata;
      end
      if (complete) begin
        if (owner == DATA) begin
          dm_rvalid_q <= 1'b1;
          dm_rdata_q  <= mem_we_q ? '0 : bus.mem_rdata;
        end else begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_req   = (state == BUSY);
  assign bus.busy      = (state == BUSY);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Transaction-level model: the transaction in flight, who was served last, and what each side should see.
  bit          m_busy;
  bit          m_last_dm;
  bit          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit          e_if_rvalid, e_dm_rvalid;
  logic [DW-1:0] e_if_rdata, e_dm_rdata;

  bit          obs_if_gnt, obs_dm_gnt, obs_if_rvalid, obs_dm_rvalid, obs_we;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata, obs_if_rdata, obs_dm_rdata;
  int          obs_log[$];
  int          obs_cyc[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic modelReset();
    m_busy      = 1'b0;
    m_last_dm   = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    e_if_rvalid = 1'b0;
    e_dm_rvalid = 1'b0;
    e_if_rdata  = '0;
    e_dm_rdata  = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_req"},   64'(bus.mem_req),   64'd0);
    checkOutput({tag, "_mem_we"},    64'(bus.mem_we),    64'd0);
    checkOutput({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
    checkOutput({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    checkOutput({tag, "_if_gnt"},    64'(bus.if_gnt),    64'd0);
    checkOutput({tag, "_dm_gnt"},    64'(bus.dm_gnt),    64'd0);
    checkOutput({tag, "_if_rvalid"}, 64'(bus.if_rvalid), 64'd0);
    checkOutput({tag, "_dm_rvalid"}, 64'(bus.dm_rvalid), 64'd0);
    checkOutput({tag, "_if_rdata"},  64'(bus.if_rdata),  64'd0);
    checkOutput({tag, "_dm_rdata"},  64'(bus.dm_rdata),  64'd0);
    checkOutput({tag, "_busy"},      64'(bus.busy),      64'd0);
  endtask

  // One clock cycle: drive inputs at the falling edge, check against the model, then advance the model at the rising edge.
  task automatic applyStimulus(input bit ir, input logic [AW-1:0] ia,
                               input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                               input bit ack, input logic [DW-1:0] rd);
    bit eg_if, eg_dm;
    @(negedge clk);
    bus.if_req    = ir;
    bus.if_addr   = ia;
    bus.dm_req    = dr;
    bus.dm_we     = dw;
    bus.dm_addr   = da;
    bus.dm_wdata  = dwd;
    bus.mem_ack   = ack;
    bus.mem_rdata = rd;
    #1;
    eg_dm = !m_busy && dr && (!ir || !RR || !m_last_dm);
    eg_if = !m_busy && ir && !eg_dm;

    obs_if_gnt    = bus.if_gnt;
    obs_dm_gnt    = bus.dm_gnt;
    obs_if_rvalid = bus.if_rvalid;
    obs_dm_rvalid = bus.dm_rvalid;
    obs_if_rdata  = bus.if_rdata;
    obs_dm_rdata  = bus.dm_rdata;
    obs_we        = bus.mem_we;
    obs_addr      = bus.mem_addr;
    obs_wdata     = bus.mem_wdata;
    if (obs_if_gnt || obs_dm_gnt) begin
      obs_log.push_back(obs_dm_gnt ? 1 : 0);
      obs_cyc.push_back(cycle);
    end

    checkOutput("if_gnt",    64'(obs_if_gnt),    64'(eg_if));
    checkOutput("dm_gnt",    64'(obs_dm_gnt),    64'(eg_dm));
    checkOutput("busy",      64'(bus.busy),      64'(m_busy));
    checkOutput("mem_req",   64'(bus.mem_req),   64'(m_busy));
    checkOutput("if_rvalid", 64'(obs_if_rvalid), 64'(e_if_rvalid));
    checkOutput("dm_rvalid", 64'(obs_dm_rvalid), 64'(e_dm_rvalid));
    checkOutput("if_rdata",  64'(obs_if_rdata),  64'(e_if_rdata));
    checkOutput("dm_rdata",  64'(obs_dm_rdata),  64'(e_dm_rdata));
    if (m_busy) begin
      checkOutput("mem_addr",  64'(obs_addr),  64'(m_addr));
      checkOutput("mem_we",    64'(obs_we),    64'(m_we));
      checkOutput("mem_wdata", 64'(obs_wdata), 64'(m_wdata));
    end

    @(posedge clk);
    e_if_rvalid = 1'b0;
    e_dm_rvalid = 1'b0;
    if (m_busy) begin
      if (ack) begin
        m_busy = 1'b0;
        if (m_last_dm) begin
          e_dm_rvalid = 1'b1;
          e_dm_rdata  = m_we ? '0 : rd;
        end else begin
          e_if_rvalid = 1'b1;
          e_if_rdata  = rd;
        end
      end
    end else if (eg_if || eg_dm) begin
      m_busy    = 1'b1;
      m_last_dm = eg_dm;
      m_we      = eg_dm ? dw : 1'b0;
      m_addr    = eg_dm ? da : ia;
      m_wdata   = eg_dm ? dwd : '0;
    end
    cycle++;
  endtask

  task automatic idleCycle(input bit ack);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, ack, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ip, dp, dwv;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dd;

    reset         = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    modelReset();
    #12;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Fetch only: ack three cycles after mem_req rises.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, 1'b0, 32'h0);
    checkOutput("tp_fetch_gnt", 64'(obs_if_gnt), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 32'h0);
    checkOutput("tp_fetch_addr", 64'(obs_addr), 64'h40);
    checkOutput("tp_fetch_we",   64'(obs_we),   64'd0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 32'hDEADBEEF);
    idleCycle(1'b0);
    checkOutput("tp_fetch_rvalid",   64'(obs_if_rvalid), 64'd1);
    checkOutput("tp_fetch_rdata",    64'(obs_if_rdata),  64'hDEADBEEF);
    checkOutput("tp_fetch_dm_quiet", 64'(obs_dm_rvalid), 64'd0);

    // Store.
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h100, 32'h12345678, 1'b0, 32'h0);
    checkOutput("tp_store_gnt", 64'(obs_dm_gnt), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 32'h0);
    checkOutput("tp_store_we",    64'(obs_we),    64'd1);
    checkOutput("tp_store_wdata", 64'(obs_wdata), 64'h12345678);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 32'hAAAA5555);
    idleCycle(1'b0);
    checkOutput("tp_store_rvalid", 64'(obs_dm_rvalid), 64'd1);
    checkOutput("tp_store_rdata",  64'(obs_dm_rdata),  64'd0);
    checkOutput("tp_store_if_hold", 64'(obs_if_rdata), 64'hDEADBEEF);

    // Tie under continuous contention, starting from a fresh reset.
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    obs_log.delete();
    obs_cyc.delete();
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h0, 1'b1, 32'h0000C0DE);
    idleCycle(1'b0);
    checkOutput("tp_tie_count", 64'(obs_log.size()), 64'd4);
    if (obs_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("tp_tie_order", 64'(obs_log[i]), RR ? 64'((i % 2 == 0) ? 1 : 0) : 64'd1);
        if (i > 0) checkOutput("tp_tie_spacing", 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd2);
      end
    end

    // Requests arriving while busy wait for the cycle after mem_ack.
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, '0, '0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
      checkOutput("tp_wait_no_gnt", 64'(obs_dm_gnt), 64'd0);
      checkOutput("tp_wait_addr",   64'(obs_addr),   64'h200);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'h11112222);
    checkOutput("tp_wait_ack_no_gnt", 64'(obs_dm_gnt), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    checkOutput("tp_wait_gnt",    64'(obs_dm_gnt),    64'd1);
    checkOutput("tp_wait_rvalid", 64'(obs_if_rvalid), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 32'h0BADF00D);
    idleCycle(1'b0);
    checkOutput("tp_wait_load", 64'(obs_dm_rdata), 64'h0BADF00D);

    // Asynchronous reset while busy with an ack pending.
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, '0, '0, 1'b0, 32'h0);
    idleCycle(1'b0);
    @(negedge clk);
    #2;
    bus.if_req    = 1'b1;
    bus.dm_req    = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555AAAA;
    reset = 1'b1;
    #1;
    checkAllZero("mid_reset");
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    reset = 1'b0;
    idleCycle(1'b1);
    idleCycle(1'b0);
    checkOutput("tp_reset_no_rvalid", 64'(obs_if_rvalid || obs_dm_rvalid), 64'd0);

    // Ack while idle is ignored.
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("tp_idle_ack_busy",   64'(bus.busy), 64'd0);
    checkOutput("tp_idle_ack_rvalid", 64'(obs_if_rvalid || obs_dm_rvalid), 64'd0);

    // Random traffic; requesters hold each request until granted.
    ip = 1'b0; dp = 1'b0; dwv = 1'b0; ia = '0; da = '0; dd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ip && $urandom_range(2) == 0) begin
        ip = 1'b1;
        ia = $urandom;
      end
      if (!dp && $urandom_range(2) == 0) begin
        dp  = 1'b1;
        dwv = 1'($urandom_range(1));
        da  = $urandom;
        dd  = $urandom;
      end
      applyStimulus(ip, ia, dp, dwv, da, dd, $urandom_range(2) == 0, $urandom);
      if (obs_if_gnt) begin
        ip = 1'($urandom_range(1));
        ia = $urandom;
      end
      if (obs_dm_gnt) begin
        dp  = 1'($urandom_range(1));
        dwv = 1'($urandom_range(1));
        da  = $urandom;
        dd  = $urandom;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
